// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only master port used by sysid_checker to talk to a sysid slave.
interface sysid_checker_if;
  logic        m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;

  modport master (
    output m_address, m_read,
    input  m_waitrequest, m_readdata, m_readdatavalid
  );

  modport slave (
    input  m_address, m_read,
    output m_waitrequest, m_readdata, m_readdatavalid
  );
endinterface

// File: rtl/sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them
// against expected values, with per-phase timeout and full-sequence retry.
//
// state   | meaning
// IDLE    | waiting for start
// ID_REQ  | read of ID word (offset 0) presented, held while stalled
// ID_WAIT | ID read accepted, waiting for readdatavalid
// TS_REQ  | read of timestamp word (offset 1) presented
// TS_WAIT | timestamp read accepted, waiting for readdatavalid
// FINISH  | done pulse, result held
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h00000000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1457643642,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  sysid_checker_if.master     bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [1:0]          fail_code,
  output logic [31:0]         id_value,
  output logic [31:0]         ts_value
);

  typedef enum logic [2:0] {
    S_IDLE, S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT, S_FINISH
  } state_t;

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [3:0]  retry_cnt;

  logic in_req, in_wait, is_ts, accepted, data_ok, word_match, tmo_hit;

  always_comb begin
    in_req     = (state == S_ID_REQ) || (state == S_TS_REQ);
    in_wait    = (state == S_ID_WAIT) || (state == S_TS_WAIT);
    is_ts      = (state == S_TS_REQ) || (state == S_TS_WAIT);
    accepted   = in_req && !bus.m_waitrequest;
    // zero-latency slaves return data in the acceptance cycle itself
    data_ok    = bus.m_readdatavalid && (accepted || in_wait);
    word_match = is_ts ? (bus.m_readdata == EXPECTED_TS)
                       : (bus.m_readdata == EXPECTED_ID);
    tmo_hit    = (tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      bus.m_read    <= 1'b0;
      bus.m_address <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_code     <= 2'd0;
      id_value      <= 32'd0;
      ts_value      <= 32'd0;
      tmo_cnt       <= 16'd0;
      retry_cnt     <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_ID_REQ;
            busy          <= 1'b1;
            pass          <= 1'b0;
            fail_code     <= 2'd0;
            retry_cnt     <= 4'd0;
            tmo_cnt       <= 16'd0;
            bus.m_read    <= 1'b1;
            bus.m_address <= 1'b0;
          end
        end

        S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT: begin
          if (data_ok) begin
            bus.m_read <= 1'b0;
            if (is_ts) ts_value <= bus.m_readdata;
            else       id_value <= bus.m_readdata;
            if (!word_match) begin
              state     <= S_FINISH;
              done      <= 1'b1;
              busy      <= 1'b0;
              fail_code <= is_ts ? 2'd2 : 2'd1;
            end else if (is_ts) begin
              state <= S_FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= 1'b1;
            end else begin
              state         <= S_TS_REQ;
              tmo_cnt       <= 16'd0;
              bus.m_read    <= 1'b1;
              bus.m_address <= 1'b1;
            end
          end else if (tmo_hit) begin
            // a timed-out phase restarts the whole sequence from the ID read
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt     <= retry_cnt + 4'd1;
              state         <= S_ID_REQ;
              tmo_cnt       <= 16'd0;
              bus.m_read    <= 1'b1;
              bus.m_address <= 1'b0;
            end else begin
              state         <= S_FINISH;
              done          <= 1'b1;
              busy          <= 1'b0;
              fail_code     <= 2'd3;
              bus.m_read    <= 1'b0;
              bus.m_address <= 1'b0;
            end
          end else if (accepted) begin
            state      <= is_ts ? S_TS_WAIT : S_ID_WAIT;
            bus.m_read <= 1'b0;
            tmo_cnt    <= tmo_cnt + 16'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        S_FINISH: begin
          state         <= S_IDLE;
          bus.m_address <= 1'b0;
        end

        default: begin
          state      <= S_IDLE;
          bus.m_read <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: a programmable Avalon slave, a
// cycle-count reference model per sequence, and a monitor that checks each done.
module tb_sysid_checker;
  localparam int          T      = 8;
  localparam int          MR     = 1;
  localparam logic [31:0] EXP_ID = 32'h00000000;
  localparam logic [31:0] EXP_TS = 32'd1457643642;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [31:0] id_value, ts_value;

  sysid_checker_if bus ();

  sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(T), .MAX_RETRIES(MR)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // slave behaviour for the current sequence: stall cycles and data latency per word
  int          w1, l1, w2, l2;
  logic [31:0] id_d, ts_d;
  bit          stab_en = 1'b0;
  int          ts_acc  = 0;

  typedef struct {
    bit          pass;
    logic [1:0]  fc;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          lat;
    int          ts_reads;
    int          t0;
    int          ts_base;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_id = 32'd0;
  logic [31:0] last_ts = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: a phase costs w+1+l cycles when the slave accepts, T cycles when it never does.
  task automatic predict(output exp_t e);
    int  lat = 0, acc = 0;
    bit  fin = 1'b0;
    e.pass = 1'b0;
    e.fc   = 2'd3;
    for (int a = 0; a <= MR; a++) begin
      if (!fin) begin
        if (w1 >= T) lat += T;
        else begin
          lat += w1 + 1 + l1;
          last_id = id_d;
          if (id_d != EXP_ID) begin
            e.fc = 2'd1;
            fin  = 1'b1;
          end else if (w2 >= T) lat += T;
          else begin
            acc++;
            lat += w2 + 1 + l2;
            last_ts = ts_d;
            e.pass  = (ts_d == EXP_TS);
            e.fc    = (ts_d == EXP_TS) ? 2'd0 : 2'd2;
            fin     = 1'b1;
          end
        end
      end
    end
    e.idv      = last_id;
    e.tsv      = last_ts;
    e.lat      = lat + 1;
    e.ts_reads = acc;
  endtask

  // Avalon slave, updated on the falling edge so the DUT samples settled values
  int          wait_seen = 0, lat_left = 0;
  bit          pending = 1'b0, prev_stall = 1'b0;
  logic        wait_addr = 1'b0, prev_addr = 1'b0;
  logic [31:0] pend_data;

  always @(negedge clock) begin
    int          w, l;
    logic [31:0] d;
    bus.m_readdatavalid = 1'b0;
    bus.m_readdata      = $urandom;
    if (pending) begin
      check("one_outstanding", 64'(bus.m_read), 64'd0);
      lat_left--;
      if (lat_left == 0) begin
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = pend_data;
        pending             = 1'b0;
      end
    end else if (!busy && $urandom_range(0, 3) == 0) begin
      bus.m_readdatavalid = 1'b1;
    end
    if (stab_en && prev_stall)
      check("stall_stable", {62'd0, bus.m_read, bus.m_address}, {62'd0, 1'b1, prev_addr});
    if (bus.m_read) begin
      if (bus.m_address != wait_addr) wait_seen = 0;
      wait_addr = bus.m_address;
      w = bus.m_address ? w2 : w1;
      l = bus.m_address ? l2 : l1;
      d = bus.m_address ? ts_d : id_d;
      if (wait_seen < w) begin
        bus.m_waitrequest = 1'b1;
        wait_seen++;
        prev_stall = 1'b1;
      end else begin
        bus.m_waitrequest = 1'b0;
        wait_seen  = 0;
        prev_stall = 1'b0;
        if (bus.m_address) ts_acc++;
        if (l == 0) begin
          bus.m_readdatavalid = 1'b1;
          bus.m_readdata      = d;
        end else begin
          pending   = 1'b1;
          lat_left  = l;
          pend_data = d;
        end
      end
    end else begin
      bus.m_waitrequest = 1'b0;
      wait_seen  = 0;
      prev_stall = 1'b0;
    end
    prev_addr = bus.m_address;
  end

  // monitor
  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check("pass",      64'(pass),           64'(e.pass));
        check("fail_code", 64'(fail_code),      64'(e.fc));
        check("id_value",  64'(id_value),       64'(e.idv));
        check("ts_value",  64'(ts_value),       64'(e.tsv));
        check("latency",   64'(cyc - e.t0),     64'(e.lat));
        check("ts_reads",  64'(ts_acc - e.ts_base), 64'(e.ts_reads));
        check("busy_at_done", 64'(busy),        64'd0);
      end
    end
  end

  task automatic run_seq(input int a, input int b, input int c, input int d,
                         input logic [31:0] idd, input logic [31:0] tsd, input bit extra);
    exp_t e;
    @(negedge clock);
    w1 = a; l1 = b; w2 = c; l2 = d; id_d = idd; ts_d = tsd;
    stab_en = (a < T) && (c < T);
    predict(e);
    e.t0      = cyc;
    e.ts_base = ts_acc;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clock) start = 1'b0;
    if (extra) begin
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
    end
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      check("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      64'(busy),          64'd0);
    check({tag, "_done"},      64'(done),          64'd0);
    check({tag, "_pass"},      64'(pass),          64'd0);
    check({tag, "_fail_code"}, 64'(fail_code),     64'd0);
    check({tag, "_id_value"},  64'(id_value),      64'd0);
    check({tag, "_ts_value"},  64'(ts_value),      64'd0);
    check({tag, "_m_read"},    64'(bus.m_read),    64'd0);
    check({tag, "_m_address"}, 64'(bus.m_address), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.m_waitrequest   = 1'b0;
    bus.m_readdatavalid = 1'b0;
    bus.m_readdata      = 32'd0;
    w1 = 0; l1 = 0; w2 = 0; l2 = 0; id_d = EXP_ID; ts_d = EXP_TS;
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b0;

    run_seq(0, 0, 0, 0, EXP_ID, EXP_TS, 1'b0);          // zero-wait match, done at start+3
    run_seq(0, 0, 0, 0, 32'h00000001, EXP_TS, 1'b0);    // ID mismatch, no timestamp read
    run_seq(0, 0, 0, 0, EXP_ID, 32'd0, 1'b0);           // timestamp mismatch
    run_seq(100, 0, 0, 0, EXP_ID, EXP_TS, 1'b0);        // permanent stall: 2 x 8 cycles
    run_seq(100, 0, 0, 0, EXP_ID, EXP_TS, 1'b1);        // retry count restarts each sequence
    run_seq(3, 2, 3, 2, EXP_ID, EXP_TS, 1'b1);          // stalled slave with latency
    run_seq(4, 3, 4, 3, EXP_ID, EXP_TS, 1'b0);          // data on the last allowed cycle
    run_seq(0, 0, 100, 0, EXP_ID, EXP_TS, 1'b0);        // timestamp phase times out

    // reset while in TS_WAIT, data returns one cycle after reset
    @(negedge clock);
    w1 = 0; l1 = 0; w2 = 0; l2 = 3; id_d = EXP_ID; ts_d = EXP_TS; stab_en = 1'b1;
    start = 1'b1;
    @(negedge clock) start = 1'b0;
    @(negedge clock);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midrst");
    reset = 1'b0;
    last_id = 32'd0;
    last_ts = 32'd0;
    repeat (3) @(negedge clock);
    check_reset_outputs("postrst");
    run_seq(0, 0, 0, 0, EXP_ID, EXP_TS, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int          a, b, c, d;
      logic [31:0] idd, tsd;
      a   = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, 4);
      c   = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, 4);
      b   = $urandom_range(0, 3);
      d   = $urandom_range(0, 3);
      idd = ($urandom_range(0, 4) == 0) ? (EXP_ID ^ ($urandom | 32'd1)) : EXP_ID;
      tsd = ($urandom_range(0, 4) == 0) ? (EXP_TS ^ ($urandom | 32'd1)) : EXP_TS;
      run_seq(a, b, c, d, idd, tsd, ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
